// File: rtl/avg_sample_feeder.sv
// avg_sample_feeder
// Buffers samples in a small circular FIFO and, on request, streams the
// buffered burst to a downstream averager one sample per cycle. A FLUSH cycle
// with ADD low and a DONE pulse follows each burst so that the receiver can
// close a partial burst.
//
// Ports:
//   CLK      - single clock, rising edge
//   RST      - asynchronous active-high reset
//   WR_EN    - load strobe for WR_DATA
//   WR_DATA  - sample to buffer
//   START    - request to transmit the buffered burst
//   NUM      - registered sample presented to the averager
//   ADD      - registered sample-valid strobe
//   BUSY     - burst in progress
//   DONE     - one-cycle pulse at burst end
//   FULL     - buffer holds DEPTH entries
//   EMPTY    - buffer holds no entries
//   COUNT    - entries held
//   OVF      - sticky: a write was dropped because the buffer was full
module avg_sample_feeder #(
    parameter int unsigned W     = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         WR_EN,
    input  logic [W-1:0]                 WR_DATA,
    input  logic                         START,
    output logic [W-1:0]                 NUM,
    output logic                         ADD,
    output logic                         BUSY,
    output logic                         DONE,
    output logic                         FULL,
    output logic                         EMPTY,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT,
    output logic                         OVF
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);
    localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StSend, StFlush} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   rem_q, rem_d;     // pops still owed in the current burst
    logic [W-1:0]    num_q;
    logic            add_q, busy_q, done_q, full_q, empty_q, ovf_q;
    logic [W-1:0]    mem [DEPTH];

    logic            full_c;
    logic            pop;
    logic            wr;
    logic            drop;

    assign full_c = (count_q == DepthC);
    assign pop    = (state_q == StSend) && (rem_q != '0);
    // A simultaneous pop frees a slot, so a write at FULL is accepted then.
    assign wr     = WR_EN && (!full_c || pop);
    assign drop   = WR_EN && full_c && !pop;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        unique case (state_q)
            StIdle: begin
                if (START && (count_q != '0)) begin
                    state_d = StSend;
                    rem_d   = count_q;   // burst length fixed here; later writes wait
                end
            end
            StSend: begin
                if (rem_q == '0) begin
                    state_d = StFlush;
                end else begin
                    rem_d = rem_q - 1'b1;
                end
            end
            StFlush: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (wr) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({wr, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; only pointers and occupancy define its contents.
    always_ff @(posedge CLK) begin
        if (wr) begin
            mem[wr_ptr_q] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rem_q    <= '0;
            num_q    <= '0;
            add_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            if (pop) begin
                num_q <= mem[rd_ptr_q];
            end
            add_q    <= pop;
            // BUSY rises one edge after the START edge and falls on the FLUSH exit.
            busy_q   <= (state_q != StIdle) && (state_d != StIdle);
            done_q   <= (state_q == StSend) && (rem_q == '0);
            full_q   <= (count_d == DepthC);
            empty_q  <= (count_d == '0);
            ovf_q    <= ovf_q | drop;
        end
    end

    assign NUM   = num_q;
    assign ADD   = add_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign FULL  = full_q;
    assign EMPTY = empty_q;
    assign COUNT = count_q;
    assign OVF   = ovf_q;

endmodule

// File: tb/tb_avg_sample_feeder.sv
module tb_avg_sample_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [3:0] wr_data;
    logic       start;
    logic [3:0] num;
    logic       add;
    logic       busy;
    logic       done;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       ovf;

    int checks = 0;
    int errors = 0;
    int exp_v [8];
    int avg;

    always #5 clk = ~clk;

    avg_sample_feeder #(
        .W     (4),
        .DEPTH (8)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .WR_EN   (wr_en),
        .WR_DATA (wr_data),
        .START   (start),
        .NUM     (num),
        .ADD     (add),
        .BUSY    (busy),
        .DONE    (done),
        .FULL    (full),
        .EMPTY   (empty),
        .COUNT   (count),
        .OVF     (ovf)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int v);
        wr_en   = 1'b1;
        wr_data = 4'(v);
        cyc();
        wr_en   = 1'b0;
    endtask

    // Pulses START and follows the burst edge by edge. Buffer must hold len
    // entries beforehand. inj_k: pop index carrying a write of 5 (-1 none);
    // st_k: pop index carrying a stray START pulse (-1 none).
    task automatic do_burst(input string tag, input int len, input int inj_k,
                            input int st_k, output int avg_o);
        int sum;
        int exp_cnt;
        sum = 0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check({tag, " pre add"}, add, 0);
        check({tag, " pre busy"}, busy, 0);
        for (int k = 0; k < len; k++) begin
            if (k == inj_k) begin
                wr_en   = 1'b1;
                wr_data = 4'd5;
            end
            if (k == st_k) start = 1'b1;
            cyc();
            wr_en = 1'b0;
            start = 1'b0;
            exp_cnt = len - (k + 1) + ((inj_k >= 0 && k >= inj_k) ? 1 : 0);
            check({tag, " pop add"}, add, 1);
            check({tag, " pop num"}, num, exp_v[k]);
            check({tag, " pop busy"}, busy, 1);
            check({tag, " pop done"}, done, 0);
            check({tag, " pop count"}, count, exp_cnt);
            sum += int'(num);
        end
        cyc();
        check({tag, " flush add"}, add, 0);
        check({tag, " flush done"}, done, 1);
        check({tag, " flush busy"}, busy, 1);
        check({tag, " flush num"}, num, exp_v[len-1]);
        cyc();
        check({tag, " idle done"}, done, 0);
        check({tag, " idle busy"}, busy, 0);
        check({tag, " idle add"}, add, 0);
        check({tag, " idle num"}, num, exp_v[len-1]);
        avg_o = sum / len;
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 4'd0;
        start   = 1'b0;
        #2;
        check("rst add", add, 0);
        check("rst num", num, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst full", full, 0);
        check("rst empty", empty, 1);
        check("rst count", count, 0);
        check("rst ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;

        // Full burst 1..8
        for (int i = 1; i <= 8; i++) wr(i);
        check("full count", count, 8);
        check("full full", full, 1);
        check("full empty", empty, 0);
        exp_v = '{1, 2, 3, 4, 5, 6, 7, 8};
        do_burst("fullb", 8, -1, -1, avg);
        check("fullb avg", avg, 4);
        check("fullb empty", empty, 1);
        check("fullb count", count, 0);

        // Partial burst 9,3,6
        wr(9);
        wr(3);
        wr(6);
        exp_v[0] = 9;
        exp_v[1] = 3;
        exp_v[2] = 6;
        do_burst("part", 3, -1, -1, avg);
        check("part avg", avg, 6);
        check("part empty", empty, 1);

        // START with nothing buffered
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("empty add", add, 0);
        check("empty busy", busy, 0);
        cyc();
        check("empty add2", add, 0);
        check("empty busy2", busy, 0);
        check("empty done2", done, 0);
        cyc();
        check("empty done3", done, 0);

        // Overflow, then wrapped pointers
        for (int i = 0; i < 10; i++) begin
            wr(i);
            if (i == 7) begin
                check("ovf full8", full, 1);
                check("ovf count8", count, 8);
                check("ovf ovf8", ovf, 0);
            end
            if (i == 8) check("ovf ovf9", ovf, 1);
        end
        check("ovf count10", count, 8);
        exp_v = '{0, 1, 2, 3, 4, 5, 6, 7};
        do_burst("ovfb", 8, -1, -1, avg);
        check("ovfb ovf sticky", ovf, 1);
        wr(10);
        wr(11);
        exp_v[0] = 10;
        exp_v[1] = 11;
        do_burst("wrap", 2, -1, -1, avg);

        // Write on the 3rd pop, stray START on the 5th
        exp_v = '{2, 4, 6, 8, 10, 12, 14, 1};
        for (int i = 0; i < 8; i++) wr(exp_v[i]);
        do_burst("sim", 8, 2, 4, avg);
        check("sim count after", count, 1);
        check("sim empty after", empty, 0);
        exp_v[0] = 5;
        do_burst("sim2", 1, -1, -1, avg);
        check("sim2 empty", empty, 1);

        // Asynchronous reset after the 4th of 8 pops
        exp_v = '{3, 1, 4, 1, 5, 9, 2, 6};
        for (int i = 0; i < 8; i++) wr(exp_v[i]);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("rmb pop num", num, exp_v[k]);
            check("rmb pop add", add, 1);
        end
        #2;
        rst = 1'b1;
        #1;
        check("rmb add", add, 0);
        check("rmb busy", busy, 0);
        check("rmb count", count, 0);
        check("rmb empty", empty, 1);
        check("rmb ovf", ovf, 0);
        check("rmb full", full, 0);
        check("rmb num", num, 0);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            check("rmb post done", done, 0);
            check("rmb post add", add, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/avg_sample_feeder.md
AVG_SAMPLE_FEEDER -- requirements
Module: avg_sample_feeder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- W, 4, sample width in bits.
- DEPTH, 8, buffer entries and maximum burst length.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- CLK, in, 1, single clock; all state changes on rising edge.
- RST, in, 1, asynchronous active-high reset.
- WR_EN, in, 1, load strobe for WR_DATA.
- WR_DATA, in, W, sample to buffer.
- START, in, 1, request to transmit the buffered burst.
- NUM, out, W, sample presented to the averager.
- ADD, out, 1, sample-valid strobe to the averager.
- BUSY, out, 1, burst in progress.
- DONE, out, 1, one-cycle pulse at burst end.
- FULL, out, 1, buffer holds DEPTH entries.
- EMPTY, out, 1, buffer holds 0 entries.
- COUNT, out, 4, entries held (0..8).
- OVF, out, 1, sticky flag: a write was dropped.

REQ-003 CLK is the only clock. RST is asynchronous and active-high; polarity and synchronicity are fixed.

Function
REQ-004 Buffer SHALL be a DEPTH x W circular FIFO with 3-bit read and write pointers that wrap 7->0.
- COUNT tracks occupancy.
- FULL = (COUNT==8).
- EMPTY = (COUNT==0).

REQ-005 A write SHALL occur when WR_EN=1 and FULL=0: store WR_DATA at the write pointer, advance the pointer.

REQ-006 WR_EN=1 while FULL=1 SHALL drop the data, leave the FIFO unchanged, and set OVF=1 until RST.

REQ-007 A pop and a write in the same cycle SHALL both take effect; COUNT stays unchanged. A write is permitted at FULL only if a pop occurs that same cycle.

REQ-008 The FSM SHALL have three states: IDLE, SEND, FLUSH.

REQ-009 IDLE -> SEND SHALL occur on the rising edge where START=1 and EMPTY=0.
- Burst length L latches as COUNT at that edge (1..8).
- START with EMPTY=1 is ignored; no DONE is generated.

REQ-010 In SEND, each rising edge SHALL pop one entry into the registered NUM and set ADD=1, for exactly L consecutive cycles. Entries written during SEND are not part of the current burst.

REQ-011 After the L-th pop, the next rising edge SHALL enter FLUSH with ADD=0, DONE=1, and NUM holding its last value.

REQ-012 The edge after FLUSH SHALL return the FSM to IDLE with DONE=0. FLUSH therefore gives the receiver one ADD-low cycle, which closes a partial burst (L<8).

REQ-013 Timing for START sampled at edge t:
- ADD=1 from edge t+1 through edge t+L.
- DONE=1 for exactly the cycle after edge t+1+L.
- BUSY=1 from edge t+1 until edge t+2+L.

REQ-014 All outputs SHALL be registered. NUM and ADD change only on rising CLK edges, so a receiver sampling on the falling edge sees stable values.

REQ-015 START while BUSY=1 SHALL be ignored. No queuing occurs.

REQ-016 In IDLE, ADD SHALL be 0 and NUM SHALL hold its last transmitted value.

Reset
REQ-017 RST=1 SHALL immediately, without waiting for CLK, set:
- state=IDLE, both pointers=0, COUNT=0;
- ADD=0, NUM=0, BUSY=0, DONE=0, OVF=0;
- FULL=0, EMPTY=1.

REQ-018 RST asserted mid-burst SHALL abort the burst. Remaining buffered entries are discarded and no DONE is issued.

REQ-019 Buffer storage contents need not be cleared by RST; only pointers and COUNT are reset.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Full burst: write 1,2,3,4,5,6,7,8, then START -> NUM=1..8 with ADD=1 on 8 consecutive cycles; then ADD=0, DONE=1 for one cycle; EMPTY=1; a downstream averager outputs 4.
- Partial burst: write 9,3,6, then START -> NUM=9,3,6 with ADD=1 for 3 cycles; then ADD=0, DONE=1; averager outputs 6.
- Overflow and wrap: write 10 samples 0..9 -> FULL=1 after the 8th; OVF=1 after the 9th; COUNT=8. Run a burst of 0..7, then write A,B -> pointers wrap; the next burst sends A,B.
- Simultaneous events: start a burst of L=8; assert WR_EN with 5 on the 3rd pop cycle -> COUNT unchanged that cycle; burst still sends 8 entries; COUNT=1 after DONE; a second START sends 5. START pulsed during SEND -> no effect.
- Empty START: START with EMPTY=1 -> ADD, BUSY, DONE stay 0.
- Reset mid-burst: assert RST asynchronously after the 4th of 8 pops -> ADD, BUSY, COUNT go to 0 and EMPTY=1 before the next edge; no DONE; OVF=0.
